// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline front end.
// Ports: clk/rst; ID source regs and valid; EX/MEM writeback info;
//   exe_is_mul, forwarding_en, branch_taken in;
//   PC/IF/ID freeze, IF/ID flushes, ID/EX ld, EX/MEM bubble,
//   mul_done, mul_busy out.
module pipeline_hazard_controller #(
    parameter int MUL_CYCLES      = 4,
    parameter int REG_ADDRESS_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_ADDRESS_LEN-1:0] id_src1,
    input  logic [REG_ADDRESS_LEN-1:0] id_src2,
    input  logic                       id_two_src,
    input  logic                       exe_wb_en,
    input  logic [REG_ADDRESS_LEN-1:0] exe_dest,
    input  logic                       exe_mem_read,
    input  logic                       exe_is_mul,
    input  logic                       mem_wb_en,
    input  logic [REG_ADDRESS_LEN-1:0] mem_dest,
    input  logic                       forwarding_en,
    input  logic                       branch_taken,
    output logic                       pc_freeze,
    output logic                       if_id_freeze,
    output logic                       if_flush,
    output logic                       id_flush,
    output logic                       id_ex_ld,
    output logic                       exe_mem_bubble,
    output logic                       mul_done,
    output logic                       mul_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_LAST = 2'd2
    } state_t;

    // Trigger cycle and MUL_LAST are not counted, hence the -3.
    localparam logic [3:0] CNT_INIT =
        (MUL_CYCLES > 2) ? 4'(MUL_CYCLES - 3) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic mul_trigger;
    logic mul_stall;
    logic ex_src1;
    logic ex_src2;
    logic mem_src1;
    logic mem_src2;
    logic m1;
    logic m2;
    logic hazard;

    assign mul_trigger = (state == IDLE) && exe_is_mul;
    assign mul_stall   = mul_trigger || (state == MUL_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (mul_trigger) begin
                    if (MUL_CYCLES == 2) begin
                        state_nxt = MUL_LAST;
                    end else begin
                        state_nxt = MUL_RUN;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            MUL_RUN: begin
                if (cnt == 4'd0) begin
                    state_nxt = MUL_LAST;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            // The multiply leaves EX now; no retrigger from here.
            MUL_LAST: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign ex_src1  = id_src1 == exe_dest;
    assign ex_src2  = id_two_src && (id_src2 == exe_dest);
    assign mem_src1 = id_src1 == mem_dest;
    assign mem_src2 = id_two_src && (id_src2 == mem_dest);

    assign m1 = id_valid && exe_wb_en && (ex_src1 || ex_src2);
    assign m2 = id_valid && mem_wb_en && (mem_src1 || mem_src2);

    // With forwarding only a load in EX cannot be bypassed.
    assign hazard = forwarding_en ? (m1 && exe_mem_read)
                                  : (m1 || m2);

    assign mul_busy = mul_stall;
    assign mul_done = (state == MUL_LAST);

    // Multiply stall outranks branch; an illegal branch during
    // the stall is simply ignored.
    always_comb begin
        pc_freeze      = 1'b0;
        if_id_freeze   = 1'b0;
        if_flush       = 1'b0;
        id_flush       = 1'b0;
        id_ex_ld       = 1'b1;
        exe_mem_bubble = 1'b0;
        if (mul_stall) begin
            pc_freeze      = 1'b1;
            if_id_freeze   = 1'b1;
            id_ex_ld       = 1'b0;
            exe_mem_bubble = 1'b1;
        end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (hazard) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_flush     = 1'b1;
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage ARM pipeline. Drives the freeze and flush controls of the PC, IF/ID and ID/EX stage registers, and the load enable of the ID/EX register. It combines three inputs: combinational data-hazard detection (with or without forwarding), branch flush, and a counter-based FSM that holds a multiply in EX for a fixed number of cycles.

## Interface
Parameters:
- MUL_CYCLES, 4, total cycles a multiply occupies EX; legal range 2..15
- REG_ADDRESS_LEN, 4, register address width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  instruction in ID reads source registers
- id_src1  in  REG_ADDRESS_LEN  first source register (Rn)
- id_src2  in  REG_ADDRESS_LEN  second source register (Rm/Rd for store)
- id_two_src  in  1  id_src2 is actually read
- exe_wb_en  in  1  instruction in EX writes back
- exe_dest  in  REG_ADDRESS_LEN  EX destination
- exe_mem_read  in  1  EX instruction is a load
- exe_is_mul  in  1  EX instruction is a multiply (ID/EX is_mul output)
- mem_wb_en  in  1  instruction in MEM writes back
- mem_dest  in  REG_ADDRESS_LEN  MEM destination
- forwarding_en  in  1  forwarding unit active
- branch_taken  in  1  branch resolved taken in EX
- pc_freeze  out  1  hold PC
- if_id_freeze  out  1  hold IF/ID register
- if_flush  out  1  bubble into IF/ID
- id_flush  out  1  flush input of ID/EX register (bubble)
- id_ex_ld  out  1  ld input of ID/EX register
- exe_mem_bubble  out  1  force EX/MEM control bits to zero
- mul_done  out  1  final EX cycle of a multiply
- mul_busy  out  1  multiply stall in progress

## Operation
- State register: IDLE, MUL_RUN, MUL_LAST; 4-bit counter cnt.
- mul_trigger = (state==IDLE) && exe_is_mul.
- Transitions:
  - IDLE and mul_trigger: go to MUL_LAST if MUL_CYCLES==2; otherwise go to MUL_RUN and load cnt=MUL_CYCLES-3.
  - MUL_RUN: if cnt==0, go to MUL_LAST; otherwise cnt decrements.
  - MUL_LAST: go to IDLE unconditionally. The multiply leaves EX this cycle, so no retrigger occurs.
- mul_stall = mul_trigger || state==MUL_RUN.
- mul_busy = mul_stall. mul_done = (state==MUL_LAST).
- Data hazard:
  - m1 = id_valid && exe_wb_en && id_src1==exe_dest, or the same test with id_src2 gated by id_two_src.
  - m2 = the same tests against mem_wb_en/mem_dest.
  - forwarding_en=1: hazard = m1 && exe_mem_read.
  - forwarding_en=0: hazard = m1 || m2.
- Output priority, highest first:
  1. mul_stall: pc_freeze=if_id_freeze=1, id_ex_ld=0, exe_mem_bubble=1, id_flush=0, if_flush=0.
  2. branch_taken: if_flush=id_flush=1, no freezes, id_ex_ld=1.
  3. hazard: pc_freeze=if_id_freeze=1, id_flush=1, id_ex_ld=1.
  4. Otherwise all outputs 0 except id_ex_ld=1.
- branch_taken while mul_stall=1 is illegal; the bench flags it with an assertion, and the controller ignores it.

## Timing
- All outputs are combinational from state and inputs. The only sequential elements are state and cnt.
- Reset: while rst is high, state=IDLE and cnt=0 asynchronously. With idle inputs the outputs are then pc_freeze=if_id_freeze=if_flush=id_flush=exe_mem_bubble=mul_done=mul_busy=0 and id_ex_ld=1.
- Multiply occupancy of EX is exactly MUL_CYCLES cycles: the trigger cycle, MUL_CYCLES-2 MUL_RUN cycles, and MUL_LAST. Front-end freeze lasts MUL_CYCLES-1 cycles.
- Back-to-back multiplies: the second enters EX in the cycle after MUL_LAST and retriggers from IDLE with no gap.
- A hazard against the multiply destination is masked while mul_stall=1. It is re-evaluated after the multiply moves to MEM.
- A hazard stall lasts one cycle per load-use with forwarding, and up to two cycles without forwarding.
- Reset mid-multiply: FSM returns to IDLE immediately and all freezes drop in the same cycle.

## Test plan
- Idle pipeline, no hazards: all outputs 0 except id_ex_ld=1 for 10 cycles, including immediately after rst is released.
- forwarding_en=1, EX load to R3 (exe_mem_read=1, exe_wb_en=1, exe_dest=3), ID id_src1=3: pc_freeze=if_id_freeze=id_flush=1 for 1 cycle, then 0.
- forwarding_en=0, MEM writes R5 and ID reads id_src2=5 with id_two_src=1: stall and bubble asserted. Repeat with id_two_src=0: no stall.
- MUL_CYCLES=4, exe_is_mul=1 held while the multiply sits in EX:
  - mul_busy=1 for 3 cycles, then mul_done=1 for 1 cycle;
  - id_ex_ld=0 and exe_mem_bubble=1 for 3 cycles;
  - a back-to-back second multiply gives the same pattern with no idle cycle between.
- branch_taken=1 together with a load-use hazard: if_flush=id_flush=1 and pc_freeze=0 (branch wins).
- rst asserted in the second MUL_RUN cycle: mul_busy=0 and id_ex_ld=1 at once; after release, IDLE behaviour resumes.
